// File: rtl/uart_tx_serializer_if.sv
// Transmit FIFO pop handshake between the TX FIFO and the serializer.
//   fifo_empty : FIFO holds no data
//   fifo_data  : head byte (first-word fall-through, valid when fifo_empty=0)
//   fifo_pop   : one-cycle strobe; the head byte is consumed in that cycle
// master = consumer that issues the pop (serializer), slave = FIFO side.
interface uart_tx_serializer_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_pop
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_pop
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Drains bytes from the TX FIFO and frames each one as
// start bit, 8 data bits LSB-first, optional parity bit and one stop bit.
// Bit period P = (baud_latched + 1) * OVERSAMPLE clocks.
//   clk    : system clock, rising-edge
//   reset  : synchronous active-high reset, highest priority
//   en     : peripheral enable; low forces idle and aborts any frame
//   baud   : baud divisor, latched at each frame start
//   fifo   : pop handshake to the TX FIFO (master side)
//   tx     : serial line, idle high (registered)
//   busy   : frame in progress (registered)
//   txdone : one-cycle pulse after a stop bit completes (registered)
// PARITY: 0 = none, 1 = even, 2 = odd.
module uart_tx_serializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [7:0]                  baud,
  uart_tx_serializer_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic                        txdone
);

  localparam int unsigned    SubW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SubW-1:0] SubLast  = SubW'(OVERSAMPLE - 1);
  localparam logic           HasParity = (PARITY != 0);
  localparam logic           ParOdd    = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      baud_q, baud_d;
  logic [7:0]      presc_q, presc_d;
  logic [SubW-1:0] sub_q, sub_d;
  logic [2:0]      idx_q, idx_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            txdone_q, txdone_d;
  logic            bit_end;
  logic            pop;

  // Last clock of the current bit: prescaler at its wrap value on the last subtick.
  assign bit_end = (presc_q == baud_q) && (sub_q == SubLast);

  // Pop from idle, or on the last stop clock so frames run back-to-back.
  // Reset gates the strobe so nothing is consumed while reset is held.
  assign pop = en && !reset && !fifo.fifo_empty &&
               ((state_q == StIdle) || ((state_q == StStop) && bit_end));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      baud_q   <= '0;
      presc_q  <= '0;
      sub_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      txdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      presc_q  <= presc_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      txdone_q <= txdone_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    presc_d = presc_q;
    sub_d   = sub_q;
    idx_d   = idx_q;

    // Bit timer: prescaler 0..baud_q, subcounter steps on each prescaler wrap.
    if (state_q != StIdle) begin
      if (bit_end) begin
        presc_d = '0;
        sub_d   = '0;
      end else if (presc_q == baud_q) begin
        presc_d = '0;
        sub_d   = sub_q + 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          shift_d = fifo.fifo_data;
          baud_d  = baud;
          presc_d = '0;
          sub_d   = '0;
          idx_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = HasParity ? StParity : StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (pop) begin
            state_d = StStart;
            shift_d = fifo.fifo_data;
            baud_d  = baud;
            presc_d = '0;
            sub_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable aborts the frame and clears the counters.
    if (!en) begin
      state_d = StIdle;
      presc_d = '0;
      sub_d   = '0;
      idx_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[idx_d];
      StParity: tx_d = (^shift_d) ^ ParOdd;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d   = (state_d != StIdle);
    txdone_d = en && (state_q == StStop) && bit_end;
  end

  assign fifo.fifo_pop = pop;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign txdone        = txdone_q;

endmodule
